// File: rtl/oddrx2_tx_pkg.sv
// +------------------------------------------------------------------+
// | oddrx2_tx_pkg : shared types and widths for the x2 TX gearbox     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package oddrx2_tx_pkg;

   localparam int WORD_W = 4;
   localparam int CNT_W  = 8;

   typedef enum logic [0:0] {
      ST_TRAIN = 1'b0,
      ST_DATA  = 1'b1
   } tx_state_t;

endpackage : oddrx2_tx_pkg

`default_nettype wire

// File: rtl/oddrx2_tx_fifo.sv
// +------------------------------------------------------------------+
// | oddrx2_tx_fifo : synchronous word FIFO feeding the TX gearbox     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module oddrx2_tx_fifo
   import oddrx2_tx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [WORD_W-1:0] i_din,
   input  logic              i_pop,
   output logic              o_full,
   output logic              o_empty,
   output logic [WORD_W-1:0] o_head
);

   localparam int           c_aw      = $clog2(DEPTH);
   localparam logic [c_aw:0] c_ptr_one = {{c_aw{1'b0}}, 1'b1};

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [c_aw:0]     r_wr_ptr;
   logic [c_aw:0]     r_rd_ptr;
   logic              w_push;
   logic              w_pop;

   // Extra MSB on each pointer distinguishes full from empty.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                    (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
   assign o_head  = r_mem[r_rd_ptr[c_aw-1:0]];

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[c_aw-1:0]] <= i_din;
   end

endmodule : oddrx2_tx_fifo

`default_nettype wire

// File: rtl/oddrx2_gearbox_tx.sv
// +------------------------------------------------------------------+
// | oddrx2_gearbox_tx : 4-bit to 2x2-bit ODDR gearbox with training   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module oddrx2_gearbox_tx
   import oddrx2_tx_pkg::*;
#(
   parameter int                DEPTH      = 4,
   parameter logic [WORD_W-1:0] TRAIN_WORD = 4'b1100,
   parameter logic [WORD_W-1:0] IDLE_WORD  = 4'b0000,
   parameter int                TRAIN_LEN  = 32
) (
   input  logic              ECLK,
   input  logic              RST,
   input  logic [WORD_W-1:0] DIN,
   input  logic              VALID,
   output logic              READY,
   input  logic              TRAIN,
   output logic              DOP,
   output logic              DON,
   output logic              UPDATE,
   output logic              TXLOCK,
   output logic              UNDERRUN
);

   localparam logic [CNT_W-1:0] c_train_len = CNT_W'(TRAIN_LEN);
   localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

   tx_state_t         r_state;
   tx_state_t         w_state_next;
   logic              r_phase;
   logic [1:0]        r_hold;
   logic [CNT_W-1:0]  r_count;
   logic              r_dop;
   logic              r_don;
   logic              r_underrun;

   logic              w_load;
   logic [WORD_W-1:0] w_word;
   logic              w_pop;
   logic [CNT_W-1:0]  w_count_next;
   logic              w_underrun_next;
   logic              w_full;
   logic              w_empty;
   logic [WORD_W-1:0] w_head;

   oddrx2_tx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (ECLK),
      .rst     (RST),
      .i_push  (VALID),
      .i_din   (DIN),
      .i_pop   (w_pop),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_head  (w_head)
   );

   assign w_load = r_phase;

   always_ff @(posedge ECLK or posedge RST) begin
      if (RST) r_state <= ST_TRAIN;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (w_load) begin
         case (r_state)
            ST_TRAIN: if (!TRAIN && (r_count == c_train_len)) w_state_next = ST_DATA;
            ST_DATA:  if (TRAIN) w_state_next = ST_TRAIN;
            default:  w_state_next = ST_TRAIN;
         endcase
      end
   end

   // Word selection follows the next state, so the lock edge already carries data.
   always_comb begin
      w_word          = TRAIN_WORD;
      w_pop           = 1'b0;
      w_count_next    = r_count;
      w_underrun_next = r_underrun;
      if (w_load) begin
         if (w_state_next == ST_DATA) begin
            if (!w_empty) begin
               w_word = w_head;
               w_pop  = 1'b1;
            end else begin
               w_word          = IDLE_WORD;
               w_underrun_next = 1'b1;
            end
         end else if (r_state == ST_DATA) begin
            w_count_next    = c_cnt_one;
            w_underrun_next = 1'b0;
         end else if (TRAIN) begin
            w_count_next = '0;
         end else begin
            w_count_next = r_count + c_cnt_one;
         end
      end
   end

   always_ff @(posedge ECLK or posedge RST) begin
      if (RST) begin
         r_phase    <= 1'b0;
         r_hold     <= 2'b00;
         r_count    <= '0;
         r_dop      <= 1'b0;
         r_don      <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_phase    <= ~r_phase;
         r_count    <= w_count_next;
         r_underrun <= w_underrun_next;
         if (w_load) begin
            r_dop  <= w_word[0];
            r_don  <= w_word[1];
            r_hold <= w_word[3:2];
         end else begin
            r_dop  <= r_hold[0];
            r_don  <= r_hold[1];
         end
      end
   end

   assign READY    = ~w_full;
   assign DOP      = r_dop;
   assign DON      = r_don;
   assign UPDATE   = r_phase;
   assign TXLOCK   = (r_state == ST_DATA);
   assign UNDERRUN = r_underrun;

endmodule : oddrx2_gearbox_tx

`default_nettype wire

// File: tb/tb_oddrx2_gearbox_tx.sv
// +------------------------------------------------------------------+
// | tb_oddrx2_gearbox_tx : directed self-checking bench, TRAIN_LEN=4  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_oddrx2_gearbox_tx;

   logic       ECLK;
   logic       RST;
   logic [3:0] DIN;
   logic       VALID;
   logic       READY;
   logic       TRAIN;
   logic       DOP;
   logic       DON;
   logic       UPDATE;
   logic       TXLOCK;
   logic       UNDERRUN;

   int compares   = 0;
   int mismatches = 0;
   int edge_n     = 0;

   oddrx2_gearbox_tx #(
      .DEPTH      (4),
      .TRAIN_WORD (4'b1100),
      .IDLE_WORD  (4'b0000),
      .TRAIN_LEN  (4)
   ) dut (
      .ECLK     (ECLK),
      .RST      (RST),
      .DIN      (DIN),
      .VALID    (VALID),
      .READY    (READY),
      .TRAIN    (TRAIN),
      .DOP      (DOP),
      .DON      (DON),
      .UPDATE   (UPDATE),
      .TXLOCK   (TXLOCK),
      .UNDERRUN (UNDERRUN)
   );

   initial ECLK = 1'b0;
   always #5 ECLK = ~ECLK;

   task automatic tick();
      @(posedge ECLK);
      edge_n++;
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge ECLK);
      #1;
      compares++;
      if ({DOP, DON, UPDATE, TXLOCK, UNDERRUN, READY} !== 6'b000001) begin
         mismatches++;
         $display("FAIL reset_state: got %b want 000001", {DOP, DON, UPDATE, TXLOCK, UNDERRUN, READY});
      end
      @(negedge ECLK);
      RST    = 1'b0;
      edge_n = 0;
   endtask

   task automatic test_training();
      logic [1:0] exp;
      for (int k = 1; k <= 9; k++) begin
         tick();
         exp = (k >= 3 && (k % 2) == 1) ? 2'b11 : 2'b00;
         compares++;
         if ({DOP, DON} !== exp || UPDATE !== 1'(k % 2) || TXLOCK !== 1'b0 || UNDERRUN !== 1'b0) begin
            mismatches++;
            $display("FAIL training_edge%0d: got pair=%b upd=%b lock=%b und=%b want pair=%b upd=%0d lock=0 und=0",
                     k, {DOP, DON}, UPDATE, TXLOCK, UNDERRUN, exp, k % 2);
         end
      end
   endtask

   task automatic test_underrun_idle();
      tick();
      compares++;
      if (TXLOCK !== 1'b1 || {DOP, DON} !== 2'b00 || UNDERRUN !== 1'b1) begin
         mismatches++;
         $display("FAIL lock_edge10: got lock=%b pair=%b und=%b want lock=1 pair=00 und=1", TXLOCK, {DOP, DON}, UNDERRUN);
      end
      tick();
      compares++;
      if ({DOP, DON} !== 2'b00 || UNDERRUN !== 1'b1) begin
         mismatches++;
         $display("FAIL idle_second_half: got pair=%b und=%b want pair=00 und=1", {DOP, DON}, UNDERRUN);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_pairs [6];
      exp_pairs = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b10, 2'b01};
      VALID = 1'b1;
      DIN   = 4'b0110;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (i == 0) DIN = 4'b1001;
         if (i == 1) VALID = 1'b0;
         compares++;
         if ({DOP, DON} !== exp_pairs[i]) begin
            mismatches++;
            $display("FAIL back_to_back_edge%0d: got pair=%b want %b", edge_n, {DOP, DON}, exp_pairs[i]);
         end
      end
      compares++;
      if (UNDERRUN !== 1'b1) begin
         mismatches++;
         $display("FAIL underrun_sticky: got %b want 1", UNDERRUN);
      end
      tick();
      compares++;
      if ({DOP, DON} !== 2'b00) begin
         mismatches++;
         $display("FAIL idle_after_data: got pair=%b want 00", {DOP, DON});
      end
   endtask

   task automatic test_train_reentry();
      TRAIN = 1'b1;
      tick();
      compares++;
      if (TXLOCK !== 1'b1 || UNDERRUN !== 1'b1) begin
         mismatches++;
         $display("FAIL reentry_nonload: got lock=%b und=%b want lock=1 und=1", TXLOCK, UNDERRUN);
      end
      tick();
      compares++;
      if (TXLOCK !== 1'b0 || UNDERRUN !== 1'b0 || {DOP, DON} !== 2'b00) begin
         mismatches++;
         $display("FAIL reentry_load: got lock=%b und=%b pair=%b want lock=0 und=0 pair=00", TXLOCK, UNDERRUN, {DOP, DON});
      end
      tick();
      compares++;
      if ({DOP, DON} !== 2'b11) begin
         mismatches++;
         $display("FAIL reentry_train_half: got pair=%b want 11", {DOP, DON});
      end
   endtask

   task automatic test_fifo_full();
      VALID = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         DIN = 4'(i);
         tick();
         compares++;
         if (READY !== (i < 4)) begin
            mismatches++;
            $display("FAIL ready_after_push%0d: got %b want %b", i, READY, (i < 4));
         end
      end
      VALID = 1'b0;
      TRAIN = 1'b0;
   endtask

   // Retained words 1..4 drain after training; the refused word 5 must not appear.
   task automatic test_fifo_drain();
      logic [1:0] exp_pairs [9];
      exp_pairs = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00};
      while (edge_n < 35) tick();
      compares++;
      if (TXLOCK !== 1'b0) begin
         mismatches++;
         $display("FAIL lock_before_edge36: got %b want 0", TXLOCK);
      end
      for (int i = 0; i < 9; i++) begin
         tick();
         compares++;
         if ({DOP, DON} !== exp_pairs[i] || TXLOCK !== 1'b1 || UNDERRUN !== (i == 8)) begin
            mismatches++;
            $display("FAIL drain_edge%0d: got pair=%b lock=%b und=%b want pair=%b lock=1 und=%b",
                     edge_n, {DOP, DON}, TXLOCK, UNDERRUN, exp_pairs[i], (i == 8));
         end
      end
   endtask

   task automatic test_reset_mid_word();
      TRAIN = 1'b1;
      VALID = 1'b1;
      DIN   = 4'hF;
      repeat (3) tick();
      VALID = 1'b0;
      compares++;
      if ({DOP, DON, UPDATE} !== 3'b111) begin
         mismatches++;
         $display("FAIL pre_reset_state: got %b want 111", {DOP, DON, UPDATE});
      end
      RST   = 1'b1;
      TRAIN = 1'b0;
      #1;
      compares++;
      if ({DOP, DON, UPDATE, TXLOCK, UNDERRUN, READY} !== 6'b000001) begin
         mismatches++;
         $display("FAIL async_reset: got %b want 000001", {DOP, DON, UPDATE, TXLOCK, UNDERRUN, READY});
      end
      @(posedge ECLK);
      #2;
      RST    = 1'b0;
      edge_n = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k <= 3 || k == 9) begin
            compares++;
            if ({DOP, DON} !== ((k == 3 || k == 9) ? 2'b11 : 2'b00) || TXLOCK !== 1'b0) begin
               mismatches++;
               $display("FAIL restart_edge%0d: got pair=%b lock=%b want pair=%b lock=0",
                        k, {DOP, DON}, TXLOCK, ((k == 3 || k == 9) ? 2'b11 : 2'b00));
            end
         end
      end
      compares++;
      if (TXLOCK !== 1'b1 || {DOP, DON} !== 2'b00 || UNDERRUN !== 1'b1) begin
         mismatches++;
         $display("FAIL fifo_flushed: got lock=%b pair=%b und=%b want lock=1 pair=00 und=1", TXLOCK, {DOP, DON}, UNDERRUN);
      end
   endtask

   initial begin
      RST   = 1'b1;
      DIN   = 4'h0;
      VALID = 1'b0;
      TRAIN = 1'b0;
      test_reset();
      test_training();
      test_underrun_idle();
      test_back_to_back();
      test_train_reentry();
      test_fifo_full();
      test_fifo_drain();
      test_reset_mid_word();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule : tb_oddrx2_gearbox_tx

`default_nettype wire
